// File: rtl/branch_predictor_if.sv
// Fetch / resolve / redirect bundle between the pipeline and branch_predictor.
// With BP_PERF_CNT_EN defined the bundle also carries the performance counters.
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic                fetch_valid;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                pred_valid;
    logic                pred_taken;
    logic                res_valid;
    logic                res_is_branch;
    logic [PC_WIDTH-1:0] res_pc;
    logic                res_taken;
    logic                res_pred_taken;
    logic [PC_WIDTH-1:0] res_target;
    logic                mispredict;
    logic [PC_WIDTH-1:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0]         perf_branches;
    logic [31:0]         perf_mispredicts;

    modport master (
        output fetch_valid, fetch_pc,
        output res_valid, res_is_branch, res_pc, res_taken, res_pred_taken, res_target,
        input  pred_valid, pred_taken, mispredict, redirect_pc,
        input  perf_branches, perf_mispredicts
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  res_valid, res_is_branch, res_pc, res_taken, res_pred_taken, res_target,
        output pred_valid, pred_taken, mispredict, redirect_pc,
        output perf_branches, perf_mispredicts
    );
`else
    modport master (
        output fetch_valid, fetch_pc,
        output res_valid, res_is_branch, res_pc, res_taken, res_pred_taken, res_target,
        input  pred_valid, pred_taken, mispredict, redirect_pc
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  res_valid, res_is_branch, res_pc, res_taken, res_pred_taken, res_target,
        output pred_valid, pred_taken, mispredict, redirect_pc
    );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: 2-bit saturating counters indexed by PC,
// registered prediction and mispredict/redirect. Optional macro: BP_PERF_CNT_EN.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter int         PC_WIDTH   = 32,
    parameter logic [1:0] RESET_CTR  = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_BITS;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b10;
            3'b1_10: nxt = 2'b11;
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b0_01: nxt = 2'b00;
            3'b0_10: nxt = 2'b01;
            3'b0_11: nxt = 2'b10;
            default: nxt = RESET_CTR;
        endcase
        return nxt;
    endfunction

    logic [1:0]            ctr_r [DEPTH];
    logic [INDEX_BITS-1:0] fidx_s;
    logic [INDEX_BITS-1:0] ridx_s;
    logic                  upd_s;
    logic [1:0]            ctr_next_s;
    logic [1:0]            pred_ctr_s;
    logic                  mis_s;
    logic [PC_WIDTH-1:0]   redirect_next_s;
    logic                  pred_valid_r;
    logic                  pred_taken_r;
    logic                  mispredict_r;
    logic [PC_WIDTH-1:0]   redirect_pc_r;
    logic                  fetch_pc_unused_s;

    assign fetch_pc_unused_s = ^{bus.fetch_pc[PC_WIDTH-1:INDEX_BITS+2], bus.fetch_pc[1:0]};

    // Index extraction, counter update value and mispredict detection.
    always_comb begin
        fidx_s     = bus.fetch_pc[INDEX_BITS+1:2];
        ridx_s     = bus.res_pc[INDEX_BITS+1:2];
        upd_s      = bus.res_valid & bus.res_is_branch;
        ctr_next_s = ctr_step(ctr_r[ridx_s], bus.res_taken);
        mis_s      = upd_s & (bus.res_taken != bus.res_pred_taken);
        if (bus.res_taken) begin
            redirect_next_s = bus.res_target;
        end else begin
            redirect_next_s = bus.res_pc + PC_WIDTH'(3'd4);
        end
    end

    // Write-through bypass: a same-index update this edge is visible to the fetch.
    always_comb begin
        pred_ctr_s = ctr_r[fidx_s];
        if (upd_s && (ridx_s == fidx_s)) begin
            pred_ctr_s = ctr_next_s;
        end else begin
            pred_ctr_s = ctr_r[fidx_s];
        end
    end

    // Counter table storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= RESET_CTR;
            end
        end else if (upd_s) begin
            ctr_r[ridx_s] <= ctr_next_s;
        end
    end

    // Registered prediction; direction holds across idle fetch cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
        end else begin
            pred_valid_r <= bus.fetch_valid;
            if (bus.fetch_valid) begin
                pred_taken_r <= pred_ctr_s[1];
            end
        end
    end

    // One-cycle mispredict pulse; redirect target holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_r  <= 1'b0;
            redirect_pc_r <= '0;
        end else begin
            mispredict_r <= mis_s;
            if (mis_s) begin
                redirect_pc_r <= redirect_next_s;
            end
        end
    end

    assign bus.pred_valid  = pred_valid_r;
    assign bus.pred_taken  = pred_taken_r;
    assign bus.mispredict  = mispredict_r;
    assign bus.redirect_pc = redirect_pc_r;

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches_r;
    logic [31:0] perf_mispredicts_r;

    // Resolved-branch and mispredict event counters, wrapping at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_r    <= 32'd0;
            perf_mispredicts_r <= 32'd0;
        end else begin
            if (upd_s) begin
                perf_branches_r <= perf_branches_r + 32'd1;
            end
            if (mis_s) begin
                perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
            end
        end
    end

    assign bus.perf_branches    = perf_branches_r;
    assign bus.perf_mispredicts = perf_mispredicts_r;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares whenever an output is valid.
module tb_branch_predictor;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit          pred_q [$];
    logic [31:0] redir_q [$];

    branch_predictor_if #(.PC_WIDTH(PW)) bus ();

    branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(PW), .RESET_CTR(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the oldest expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pred_valid) begin
                if (pred_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pred_unexpected: got pred_valid=1 expected no prediction");
                end else begin
                    check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, pred_q.pop_front()});
                end
            end
            if (bus.mispredict) begin
                if (redir_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mis_unexpected: got mispredict=1 redirect %h expected none", bus.redirect_pc);
                end else begin
                    check("redirect_pc", bus.redirect_pc, redir_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic fv, input logic [31:0] fpc,
                         input logic rv, input logic rb, input logic [31:0] rpc,
                         input logic rt, input logic rpt, input logic [31:0] rtgt,
                         input logic exp_pred, input logic exp_mis, input logic [31:0] exp_redir);
        @(negedge clk);
        bus.fetch_valid    = fv;
        bus.fetch_pc       = fpc;
        bus.res_valid      = rv;
        bus.res_is_branch  = rb;
        bus.res_pc         = rpc;
        bus.res_taken      = rt;
        bus.res_pred_taken = rpt;
        bus.res_target     = rtgt;
        if (fv) pred_q.push_back(exp_pred);
        if (exp_mis) redir_q.push_back(exp_redir);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic exp_pred);
        drive(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, exp_pred, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic pt,
                           input logic [31:0] tgt, input logic exp_mis, input logic [31:0] exp_redir);
        drive(1'b0, 32'd0, 1'b1, 1'b1, pc, t, pt, tgt, 1'b0, exp_mis, exp_redir);
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        bus.fetch_valid    = 1'b0;
        bus.fetch_pc       = 32'd0;
        bus.res_valid      = 1'b0;
        bus.res_is_branch  = 1'b0;
        bus.res_pc         = 32'd0;
        bus.res_taken      = 1'b0;
        bus.res_pred_taken = 1'b0;
        bus.res_target     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        check("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        check("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("rst_redirect",   bus.redirect_pc, 32'd0);
        rst_n = 1'b1;

        fetch(32'h100, 1'b0);
        resolve(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
        fetch(32'h100, 1'b1);
        for (int i = 0; i < 3; i++) resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'd0);
        resolve(32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h104);
        fetch(32'h100, 1'b1);
        idle();
        @(negedge clk);
        check("idle_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        check("hold_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        check("idle_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("hold_redirect",   bus.redirect_pc, 32'h104);

        // Same-index bypass, then unrelated index alongside an update.
        drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 32'h80);
        drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0);

        // Non-branch leaves the table alone; 0x200 aliases 0x100.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0);
        fetch(32'h200, 1'b1);
        resolve(32'h200, 1'b0, 1'b1, 32'h400, 1'b1, 32'h204);
        fetch(32'h100, 1'b0);

        resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234, 1'b1, 32'h0000_0000);
        resolve(32'h308, 1'b1, 1'b0, 32'hABC, 1'b1, 32'hABC);
        idle();
        @(negedge clk);
        check("after_b2b_mispredict", {31'd0, bus.mispredict}, 32'd0);
`ifdef BP_PERF_CNT_EN
        check("perf_branches",    bus.perf_branches,    32'd11);
        check("perf_mispredicts", bus.perf_mispredicts, 32'd7);
`endif

        // Asynchronous reset in the middle of a mispredict pulse.
        drive(1'b1, 32'h308, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 32'h20);
        @(posedge clk);
        #1;
        check("mis_before_rst", {31'd0, bus.mispredict}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("rst_mid_redirect",   bus.redirect_pc, 32'd0);
        check("rst_mid_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        check("rst_mid_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        pred_q.delete();
        redir_q.delete();
        bus.fetch_valid = 1'b0;
        bus.res_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef BP_PERF_CNT_EN
        check("perf_branches_rst",    bus.perf_branches,    32'd0);
        check("perf_mispredicts_rst", bus.perf_mispredicts, 32'd0);
`endif
        fetch(32'h308, 1'b0);
        fetch(32'h100, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        check("pred_queue_drained",  pred_q.size(),  32'd0);
        check("redir_queue_drained", redir_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor with resolution logic.
- Fetch stage queries a table of 2-bit saturating counters indexed by PC and gets a registered taken/not-taken prediction.
- Execute stage feeds back the resolved outcome: is_branch plus the taken result from the execute-stage branch comparator. The block then updates the table and raises a registered mispredict/redirect to the fetch PC mux.

Parameters:
- INDEX_BITS, 6, log2 of counter table depth (64 entries); index = pc[INDEX_BITS+1:2].
- PC_WIDTH, 32, width of all PC/target buses.
- RESET_CTR, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_valid  input  1  fetch stage presents a PC this cycle.
- fetch_pc  input  PC_WIDTH  PC being fetched.
- pred_valid  output  1  prediction for the previous cycle's fetch_pc is valid.
- pred_taken  output  1  predicted direction (counter MSB).
- res_valid  input  1  execute stage has a resolved instruction this cycle.
- res_is_branch  input  1  resolved instruction is a conditional branch.
- res_pc  input  PC_WIDTH  PC of the resolved instruction.
- res_taken  input  1  actual outcome from the execute-stage branch comparator.
- res_pred_taken  input  1  prediction that was carried down the pipe with this instruction.
- res_target  input  PC_WIDTH  computed branch target.
- mispredict  output  1  one-cycle pulse: prediction was wrong, flush younger stages.
- redirect_pc  output  PC_WIDTH  correct next PC, valid while mispredict=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all counters = RESET_CTR; pred_valid=0, pred_taken=0, mispredict=0, redirect_pc=0. Reset asserted mid-operation discards pending prediction and mispredict immediately.

Prediction, latency 1:
- When fetch_valid=1 at edge N, at N+1 pred_valid=1 and pred_taken=ctr[fidx][1].
- When fetch_valid=0, pred_valid=0 next cycle and pred_taken holds its value.

Update:
- Applies on an edge with res_valid & res_is_branch, at ridx = res_pc[INDEX_BITS+1:2].
- res_taken=1: counter increments, saturating at 2'b11.
- res_taken=0: counter decrements, saturating at 2'b00.
- res_valid=1 with res_is_branch=0: no update, no mispredict.

Simultaneous fetch and update to the same index:
- The prediction uses the post-update counter value (write-through bypass).
- A different index has no interaction.

Mispredict, latency 1:
- At edge N, when res_valid & res_is_branch & (res_taken != res_pred_taken): mispredict=1 for exactly cycle N+1.
- redirect_pc = res_taken ? res_target : res_pc + 4, modulo 2^PC_WIDTH (wrap at all-ones).
- Otherwise mispredict=0 and redirect_pc holds its value.
- Back-to-back mispredicts produce back-to-back pulses, each carrying its own redirect_pc.

Aliasing: PCs sharing index bits share a counter. No tags.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
  - Both reset to 0 on rst_n.
  - perf_branches increments on each edge with res_valid & res_is_branch.
  - perf_mispredicts increments on each mispredict detection.
  - Both wrap 0xFFFFFFFF -> 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_valid=1, pred_taken=0 next cycle (ctr=01).
- Two resolves res_pc=0x100, res_taken=1, res_pred_taken=0 -> mispredict pulses, redirect_pc=res_target=0x200; ctr 01->10->11; next fetch 0x100 predicts taken.
- Saturation: 3 more taken resolves -> ctr stays 11; then 1 not-taken (res_pred_taken=1) -> mispredict, redirect_pc=0x104, ctr=10, still predicts taken.
- Same-cycle fetch_pc=0x40 with taken resolve res_pc=0x40 from ctr=01 -> pred_taken reflects 10, i.e. 1.
- Non-branch res_valid with res_taken != res_pred_taken -> no mispredict, table unchanged. Aliasing check: 0x100 and 0x200 (INDEX_BITS=6) share a counter.
- res_pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x00000000. Assert rst_n mid-pulse -> mispredict drops immediately. With BP_PERF_CNT_EN, counts match the totals in the scenarios above.
